// File: rtl/accumulator_drain_unit.sv
// accumulator_drain_unit
// Drains finished accumulator rows into the unified buffer. Each row is read,
// requantized lane by lane (rounding arithmetic right shift, optional ReLU,
// saturation to OUT_WIDTH), then queued in a 3-entry FIFO that feeds a
// valid/ready write port. Reads are only issued while a FIFO slot is guaranteed,
// so returning data never has to be dropped.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   start_i ..shift_i   drain command; parameters are latched on an accepted start
//   acc_rd_*            accumulator read port (data valid one cycle after enable)
//   ub_wr_*             unified buffer write port (valid/ready)
//   busy_o, done_o      drain in progress / one-cycle completion pulse
module accumulator_drain_unit #(
  parameter int unsigned MUL_SIZE  = 32,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned UB_ADDR_W = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [9:0]                     num_rows_i,
  input  logic [9:0]                     acc_base_i,
  input  logic [UB_ADDR_W-1:0]           ub_base_i,
  input  logic                           relu_en_i,
  input  logic [4:0]                     shift_i,
  output logic                           acc_rd_en_o,
  output logic [9:0]                     acc_rd_addr_o,
  input  logic [MUL_SIZE*ACC_WIDTH-1:0]  acc_rd_data_i,
  output logic                           ub_wr_valid_o,
  input  logic                           ub_wr_ready_i,
  output logic [UB_ADDR_W-1:0]           ub_wr_addr_o,
  output logic [MUL_SIZE*OUT_WIDTH-1:0]  ub_wr_data_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned RowW = MUL_SIZE * OUT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  state_e                 r_state, w_state_nxt;
  logic [9:0]             r_num_rows, r_acc_base, r_rd_cnt, r_wr_cnt;
  logic [UB_ADDR_W-1:0]   r_ub_base;
  logic                   r_relu_en, r_inflight, r_zero_done;
  logic [4:0]             r_shift;
  logic [1:0]             r_wr_ptr, r_rd_ptr, r_fifo_cnt;
  logic [RowW-1:0]        r_fifo_mem [3];

  logic                   w_start_acc, w_rd_ok, w_last_rd, w_flush_cond, w_pop;
  logic [RowW-1:0]        w_row;
  logic [UB_ADDR_W+9:0]   w_ub_sum;

  // Lane requantization, evaluated in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [4:0]           sh,
                                                   input logic                 relu);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] r;
    ext  = $signed({x[ACC_WIDTH-1], x});
    half = {{ACC_WIDTH{1'b0}}, 1'b1} << (sh - 5'd1);
    r    = (sh == 5'd0) ? ext : ((ext + half) >>> sh);
    if (relu && r[ACC_WIDTH]) r = '0;
    if (r > SatMax) r = SatMax;
    else if (r < SatMin) r = SatMin;
    return r[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
    assign w_row[gi*OUT_WIDTH +: OUT_WIDTH] =
        requant(acc_rd_data_i[gi*ACC_WIDTH +: ACC_WIDTH], r_shift, r_relu_en);
  end

  assign w_start_acc = (r_state == StIdle) && start_i;
  // Credit check uses registered occupancy only, keeping ub_wr_ready_i off the read path.
  assign w_rd_ok      = (r_rd_cnt < r_num_rows) &&
                        (({1'b0, r_fifo_cnt} + {2'b00, r_inflight}) < 3'd3);
  assign w_last_rd    = (r_rd_cnt == r_num_rows - 10'd1);
  assign w_flush_cond = !r_inflight && (r_fifo_cnt == 2'd0) && (r_wr_cnt == r_num_rows);
  assign w_pop        = ub_wr_valid_o && ub_wr_ready_i;

  assign acc_rd_addr_o = r_acc_base + r_rd_cnt;
  assign w_ub_sum      = {{UB_ADDR_W{1'b0}}, r_wr_cnt} + {10'd0, r_ub_base};
  assign ub_wr_addr_o  = w_ub_sum[UB_ADDR_W-1:0];
  assign ub_wr_valid_o = (r_fifo_cnt != 2'd0);
  assign ub_wr_data_o  = ub_wr_valid_o ? r_fifo_mem[r_rd_ptr] : '0;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (start_i && (num_rows_i != 10'd0)) w_state_nxt = StDrain;
      StDrain: if (w_rd_ok && w_last_rd)             w_state_nxt = StFlush;
      StFlush: if (w_flush_cond)                     w_state_nxt = StIdle;
      default:                                       w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs; busy drops in the same cycle done pulses
  always_comb begin
    acc_rd_en_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = r_zero_done;
    case (r_state)
      StDrain: begin
        acc_rd_en_o = w_rd_ok;
        busy_o      = 1'b1;
      end
      StFlush: begin
        busy_o = !w_flush_cond;
        done_o = r_zero_done | w_flush_cond;
      end
      default: ;
    endcase
  end

  // Command latch, counters and FIFO bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_num_rows  <= '0;
      r_acc_base  <= '0;
      r_ub_base   <= '0;
      r_relu_en   <= 1'b0;
      r_shift     <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_inflight  <= 1'b0;
      r_zero_done <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
    end else begin
      r_zero_done <= 1'b0;
      if (w_start_acc) begin
        r_num_rows  <= num_rows_i;
        r_acc_base  <= acc_base_i;
        r_ub_base   <= ub_base_i;
        r_relu_en   <= relu_en_i;
        r_shift     <= shift_i;
        r_rd_cnt    <= '0;
        r_wr_cnt    <= '0;
        r_zero_done <= (num_rows_i == 10'd0);
      end
      if (acc_rd_en_o) r_rd_cnt <= r_rd_cnt + 10'd1;
      r_inflight <= acc_rd_en_o;
      if (r_inflight) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_wr_cnt <= r_wr_cnt + 10'd1;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Row storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk_i) begin
    if (r_inflight) r_fifo_mem[r_wr_ptr] <= w_row;
  end

endmodule

// File: tb/tb_accumulator_drain_unit.sv
// Scoreboard bench for accumulator_drain_unit: stimulus pushes expected reads
// and writes computed by a plain-arithmetic lane model; a negedge monitor pops
// and compares whenever the DUT reads or completes a write handshake.
module tb_accumulator_drain_unit;

  localparam int MUL = 32;
  localparam int AW  = 32;
  localparam int OW  = 8;
  localparam int UBW = 10;

  typedef struct {
    logic [UBW-1:0]    addr;
    logic [MUL*OW-1:0] data;
  } wexp_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [9:0]        num_rows_i = '0;
  logic [9:0]        acc_base_i = '0;
  logic [UBW-1:0]    ub_base_i = '0;
  logic              relu_en_i = 1'b0;
  logic [4:0]        shift_i = '0;
  logic              acc_rd_en_o;
  logic [9:0]        acc_rd_addr_o;
  logic [MUL*AW-1:0] acc_rd_data_i = '0;
  logic              ub_wr_valid_o;
  logic              ub_wr_ready_i = 1'b0;
  logic [UBW-1:0]    ub_wr_addr_o;
  logic [MUL*OW-1:0] ub_wr_data_o;
  logic              busy_o;
  logic              done_o;

  accumulator_drain_unit #(
    .MUL_SIZE (MUL),
    .ACC_WIDTH(AW),
    .OUT_WIDTH(OW),
    .UB_ADDR_W(UBW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .num_rows_i   (num_rows_i),
    .acc_base_i   (acc_base_i),
    .ub_base_i    (ub_base_i),
    .relu_en_i    (relu_en_i),
    .shift_i      (shift_i),
    .acc_rd_en_o  (acc_rd_en_o),
    .acc_rd_addr_o(acc_rd_addr_o),
    .acc_rd_data_i(acc_rd_data_i),
    .ub_wr_valid_o(ub_wr_valid_o),
    .ub_wr_ready_i(ub_wr_ready_i),
    .ub_wr_addr_o (ub_wr_addr_o),
    .ub_wr_data_o (ub_wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [MUL*AW-1:0] acc_mem [1024];
  int    rdq[$];
  wexp_t wq[$];

  bit active = 0, done_due = 0, start_pending = 0, start_zero = 0, done_seen = 0;
  bit post_reset = 0, prev_stall = 0;
  int outstanding = 0;
  logic [UBW-1:0]    prev_addr;
  logic [MUL*OW-1:0] prev_data;
  int start_cyc = 0, first_rd_cyc = -1, first_hs_cyc = -1, done_cyc = -1;
  int ready_mode = 0, pat_idx = 0;

  bit          pend_valid = 0;
  logic [9:0]  pend_addr = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference lane: 64-bit integer arithmetic straight from the requantization rules.
  function automatic logic [OW-1:0] ref_lane(input logic [AW-1:0] x, input int sh, input bit relu);
    longint v;
    longint mx;
    longint mn;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    v = longint'($signed(x));
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (v > mx) v = mx;
    if (v < mn) v = mn;
    return v[OW-1:0];
  endfunction

  function automatic logic [MUL*OW-1:0] ref_row(input logic [MUL*AW-1:0] row, input int sh,
                                                input bit relu);
    logic [MUL*OW-1:0] o;
    for (int l = 0; l < MUL; l++) o[l*OW +: OW] = ref_lane(row[l*AW +: AW], sh, relu);
    return o;
  endfunction

  function automatic logic [AW-1:0] rand_lane();
    logic [AW-1:0] ext [4];
    ext[0] = 32'h7fff_ffff; ext[1] = 32'h8000_0000; ext[2] = 32'h0; ext[3] = 32'hffff_ffff;
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 600) - 300;
      1:       return $urandom;
      2:       return ext[$urandom_range(0, 3)];
      default: return ($urandom_range(0, 8191) - 4096) << $urandom_range(0, 12);
    endcase
  endfunction

  task automatic fill_random(input int addr);
    for (int l = 0; l < MUL; l++) acc_mem[addr % 1024][l*AW +: AW] = rand_lane();
  endtask

  // Clock cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Accumulator model: data for a read appears one cycle later; other cycles carry junk.
  initial forever begin
    @(negedge clk);
    pend_valid = acc_rd_en_o;
    pend_addr  = acc_rd_addr_o;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (pend_valid) acc_rd_data_i = acc_mem[pend_addr];
    else for (int l = 0; l < MUL; l++) acc_rd_data_i[l*AW +: AW] = $urandom;
  end

  // Ready driver: 0 always, 1 random, 2 toggle then stall, other values hold low.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       ub_wr_ready_i = 1'b1;
      1:       ub_wr_ready_i = ($urandom_range(0, 3) != 0);
      2:       ub_wr_ready_i = (pat_idx < 8) ? (pat_idx % 2 == 0) : (pat_idx >= 13);
      default: ub_wr_ready_i = 1'b0;
    endcase
    pat_idx++;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    wexp_t e;
    if (!rst_i) begin
      rdq.delete();
      wq.delete();
      active = 0; done_due = 0; start_pending = 0; outstanding = 0;
      prev_stall = 0; post_reset = 1;
    end else begin
      if (post_reset) begin
        chk("reset_ctrl_outputs",
            {acc_rd_en_o, acc_rd_addr_o, ub_wr_valid_o, ub_wr_addr_o, busy_o, done_o}, 0);
        chk("reset_data_output", ub_wr_data_o, 0);
        post_reset = 0;
      end
      chk("done", done_o, done_due);
      if (done_o) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      chk("busy", busy_o, active);
      done_due = 0;
      if (prev_stall)
        chk("hold_under_backpressure", {ub_wr_valid_o, ub_wr_addr_o, ub_wr_data_o},
            {1'b1, prev_addr, prev_data});
      if (acc_rd_en_o) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (rdq.size() == 0) chk("rd_extra_read_queue", rdq.size(), 1);
        else chk("rd_addr", acc_rd_addr_o, rdq.pop_front());
        outstanding++;
      end
      if (ub_wr_valid_o && ub_wr_ready_i) begin
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        outstanding--;
        if (wq.size() == 0) chk("wr_extra_write_queue", wq.size(), 1);
        else begin
          e = wq.pop_front();
          chk("wr_addr", ub_wr_addr_o, e.addr);
          chk("wr_data", ub_wr_data_o, e.data);
          if (wq.size() == 0 && active) begin
            active   = 0;
            done_due = 1;
          end
        end
      end
      if (acc_rd_en_o) chk("outstanding_le3", outstanding <= 3, 1);
      prev_stall = ub_wr_valid_o && !ub_wr_ready_i;
      prev_addr  = ub_wr_addr_o;
      prev_data  = ub_wr_data_o;
      if (start_pending) begin
        if (start_zero) done_due = 1;
        else active = 1;
        start_pending = 0;
      end
    end
  end

  task automatic issue(input int n, input int ab, input int ub, input bit relu, input int sh,
                       input int mode);
    wexp_t e;
    @(posedge clk);
    #1;
    num_rows_i = n[9:0];
    acc_base_i = ab[9:0];
    ub_base_i  = ub[UBW-1:0];
    relu_en_i  = relu;
    shift_i    = sh[4:0];
    start_i    = 1'b1;
    ready_mode = mode;
    pat_idx    = 0;
    start_cyc  = cyc;
    first_rd_cyc = -1; first_hs_cyc = -1; done_cyc = -1; done_seen = 0;
    for (int i = 0; i < n; i++) begin
      rdq.push_back((ab + i) % 1024);
      e.addr = UBW'((ub + i) % (1 << UBW));
      e.data = ref_row(acc_mem[(ab + i) % 1024], sh, relu);
      wq.push_back(e);
    end
    start_zero    = (n == 0);
    start_pending = 1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_seen) break;
    end
    chk({nm, "_done_seen"}, done_seen, 1);
    chk({nm, "_writes_left"}, wq.size(), 0);
    chk({nm, "_reads_left"}, rdq.size(), 0);
  endtask

  initial begin
    int v1 [4];
    int v2 [4];
    v1 = '{5, -3, 200, -200};
    v2 = '{24, -40, 8, 2047};
    for (int a = 0; a < 1024; a++) acc_mem[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);

    // Saturation at shift 0 with exact cycle timing
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < MUL; l++) acc_mem[r][l*AW +: AW] = v1[l % 4];
    issue(4, 0, 16, 0, 0, 0);
    wait_done("t1");
    chk("t1_first_read_cycle", first_rd_cyc - start_cyc, 1);
    chk("t1_first_write_cycle", first_hs_cyc - start_cyc, 3);
    chk("t1_done_cycle", done_cyc - start_cyc, 7);

    // Rounding with ReLU at shift 4
    for (int r = 100; r < 102; r++)
      for (int l = 0; l < MUL; l++) acc_mem[r][l*AW +: AW] = v2[l % 4];
    issue(2, 100, 500, 1, 4, 0);
    wait_done("t2");

    // Backpressure pattern
    for (int r = 200; r < 208; r++) fill_random(r);
    issue(8, 200, 40, 0, 7, 2);
    wait_done("t3");

    // Address wrap on both ports
    for (int r = 1022; r < 1026; r++) fill_random(r);
    issue(4, 1022, 1022, 1, 3, 0);
    wait_done("t4");

    // Zero rows
    issue(0, 5, 5, 0, 0, 0);
    wait_done("t5");
    chk("t5_done_cycle", done_cyc - start_cyc, 1);

    // Second start while busy must be ignored
    for (int r = 300; r < 306; r++) fill_random(r);
    issue(6, 300, 700, 0, 2, 1);
    start_i = 1'b1; num_rows_i = 10'd0; acc_base_i = 10'd9; ub_base_i = '0;
    relu_en_i = 1'b1; shift_i = 5'd31;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("t6");

    // Reset in the middle of a stalled drain, then a fresh drain
    for (int r = 400; r < 408; r++) fill_random(r);
    issue(8, 400, 100, 0, 1, 3);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    repeat (6) @(posedge clk);
    for (int r = 410; r < 413; r++) fill_random(r);
    issue(3, 410, 900, 0, 31, 0);
    wait_done("t7");

    // Randomized drains
    for (int k = 0; k < 10; k++) begin
      int n, ab;
      n  = $urandom_range(1, 12);
      ab = $urandom_range(0, 1023);
      for (int r = 0; r < n; r++) fill_random(ab + r);
      issue(n, ab, $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 2));
      wait_done("rand");
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
